axis_elastic_buffer: RTL and testbench
======================================

# axis_elastic_buffer

Parametrised AXI-stream elastic buffer generalising the single-entry skid buffer to a DEPTH-entry circular store. It has an optional registered output stage, an optional store-and-forward packet mode, and fill/packet status outputs. It sits on any axi_stream link where bursts must be absorbed without back-pressuring the producer every cycle, for example ADC and DMA paths and interconnect boundaries.

## Interface
- DATA_WIDTH, 32, width of data
- DEST_WIDTH, 32, width of dest
- USER_WIDTH, 32, width of user
- DEPTH, 4, storage entries; power of two, ≥2
- REGISTER_OUTPUT, 1, 1 = extra output register stage (capacity DEPTH+1); 0 = output driven from store head
- PACKET_MODE, 0, 1 = store-and-forward on tlast; 0 = cut-through
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- axis_in  slave  axi_stream (data/dest/user/tlast/valid/ready)  input stream
- axis_out  master  axi_stream  output stream
- fill_level  out  $clog2(DEPTH)+1  entries held in store (excludes output register)
- packet_count  out  $clog2(DEPTH)+1  complete packets (tlast beats) in store and output register, not yet transferred out
- full  out  1  store holds DEPTH entries

## Operation
- Store: circular array of {data,dest,user,tlast}. Write/read pointers are $clog2(DEPTH)+1 bits; the MSB disambiguates full from empty. Pointers wrap modulo DEPTH.
- Push: axis_in.valid && axis_in.ready writes at wr_ptr, then wr_ptr++.
- Pop: occurs when the head moves to the output register, or when the head is accepted downstream (REGISTER_OUTPUT=0). Then rd_ptr++.
- fill_level = wr_ptr − rd_ptr. Simultaneous push and pop leaves it unchanged.
- axis_in.ready = ready_en && !full. ready_en is a register loaded with reset, so ready is low during reset and for the first cycle after release. full is registered.
- REGISTER_OUTPUT=1:
  - Output register loads the head when (!axis_out.valid || axis_out.ready) and the head is eligible.
  - axis_out.valid is registered.
  - Payload holds while valid && !ready.
- REGISTER_OUTPUT=0:
  - axis_out.valid = eligible head present.
  - Payload = head entry.
  - Payload is 0 when the store is empty.
- Eligibility with PACKET_MODE=0: any stored entry.
- Eligibility with PACKET_MODE=1: the head is eligible if any of the following holds:
  - packet_count_store > 0, i.e. a complete packet is held.
  - cut_through is set.
  - full && packet_count_store == 0.
- cut_through (PACKET_MODE=1 only):
  - Sets when a beat is released under the full override.
  - Clears when a tlast beat is popped.
  - This prevents deadlock on packets longer than DEPTH.
- packet_count:
  - Increments on push of a tlast beat.
  - Decrements when a tlast beat transfers on axis_out (valid && ready).
  - Simultaneous increment and decrement leaves it unchanged.
- AXI rule: once asserted, axis_out.valid and its payload must not change until axis_out.ready.

## Timing
- Reset (reset=0 at a clock edge) forces the following:
  - axis_out.valid=0; data/dest/user/tlast=0.
  - axis_in.ready=0; fill_level=0; packet_count=0; full=0.
  - Pointers cleared; cut_through=0.
- Reset mid-operation discards all contents; no beat is emitted afterward.
- Latency, input accept to axis_out.valid, on an empty buffer with PACKET_MODE=0:
  - 1 cycle for REGISTER_OUTPUT=0.
  - 2 cycles for REGISTER_OUTPUT=1.
- Latency with PACKET_MODE=1: timing is measured from acceptance of the tlast beat instead of the first beat.
- Throughput: 1 beat/cycle sustained when axis_out.ready=1.
- Full boundary:
  - The push that fills the store sets full the next cycle; ready drops that cycle.
  - The first pop from full clears full next cycle; ready rises that cycle.
  - No beat is lost or duplicated.
- Empty boundary: a pop and push in the same cycle on a single-entry store keep fill_level=1 and valid continuous.

## Test plan
- Reset release:
  - Stimulus: hold reset=0 for 3 cycles, then release, with axis_in.valid=1 throughout.
  - Required: ready=0 until 1 cycle after release; outputs stay 0 during reset.
- Streaming, DEPTH=4, REGISTER_OUTPUT=1:
  - Stimulus: beats 1..16 pushed back-to-back, axis_out.ready=1.
  - Required: first valid 2 cycles after the first accept; output 1..16 in order, one per cycle.
- Back-pressure:
  - Stimulus: axis_out.ready=0 while pushing 1..10, then ready=1.
  - Required: accepts exactly DEPTH+1=5 beats; full=1; fill_level=4; drain yields 1..5, then 6..10; no gaps or duplicates.
- Packet mode, PACKET_MODE=1, DEPTH=8:
  - Stimulus: 3-beat packet with tlast on the 3rd beat.
  - Required: axis_out.valid stays 0 until the tlast beat is accepted; packet_count=1, then 0 after the final beat.
- Oversize packet, PACKET_MODE=1, DEPTH=4:
  - Stimulus: 10-beat packet.
  - Required: the full override releases beats, cut_through holds through tlast, all 10 beats arrive in order, no deadlock.
- Reset mid-stream:
  - Stimulus: assert reset with 3 beats stored.
  - Required: fill_level=0 and valid=0 next cycle; later traffic is unaffected by the stale data.

Source files
------------

// File: rtl/axis_elastic_buffer.sv
// AXI-stream elastic buffer: DEPTH-entry circular store with an optional registered
// output stage, optional store-and-forward packet mode and fill/packet status.
module axis_elastic_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEST_WIDTH      = 32,
    parameter int USER_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int REGISTER_OUTPUT = 1,
    parameter int PACKET_MODE     = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   i_axis_in_data,
    input  logic [DEST_WIDTH-1:0]   i_axis_in_dest,
    input  logic [USER_WIDTH-1:0]   i_axis_in_user,
    input  logic                    i_axis_in_tlast,
    input  logic                    i_axis_in_valid,
    output logic                    o_axis_in_ready,
    output logic [DATA_WIDTH-1:0]   o_axis_out_data,
    output logic [DEST_WIDTH-1:0]   o_axis_out_dest,
    output logic [USER_WIDTH-1:0]   o_axis_out_user,
    output logic                    o_axis_out_tlast,
    output logic                    o_axis_out_valid,
    input  logic                    i_axis_out_ready,
    output logic [$clog2(DEPTH):0]  o_fill_level,
    output logic [$clog2(DEPTH):0]  o_packet_count,
    output logic                    o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_pkt_store;
    logic [PW-1:0] r_pkt_count;
    logic          r_ready_en;
    logic          r_full;
    logic          r_cut_through;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_eligible;
    logic          w_head_tlast;
    logic          w_out_valid;
    logic          w_out_fire;
    logic [EW-1:0] w_head;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;
    logic [PW-1:0] w_fill_next;

    assign o_axis_in_ready = r_ready_en && !r_full;
    assign w_push          = i_axis_in_valid && o_axis_in_ready;
    assign w_empty         = (r_wr_ptr == r_rd_ptr);
    assign w_head          = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_tlast    = w_head[0];
    assign w_out_fire      = w_out_valid && i_axis_out_ready;

    assign w_wr_next   = r_wr_ptr + PW'(w_push);
    assign w_rd_next   = r_rd_ptr + PW'(w_pop);
    assign w_fill_next = w_wr_next - w_rd_next;

    assign o_fill_level   = r_wr_ptr - r_rd_ptr;
    assign o_packet_count = r_pkt_count;
    assign o_full         = r_full;

    // A full store with no complete packet releases its head so long packets cannot deadlock.
    always_comb begin
        w_eligible = !w_empty;
        if (PACKET_MODE != 0) begin
            w_eligible = !w_empty &&
                         ((r_pkt_store != '0) || r_cut_through || (r_full && (r_pkt_store == '0)));
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_axis_in_data, i_axis_in_dest, i_axis_in_user, i_axis_in_tlast};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pkt_store   <= '0;
            r_pkt_count   <= '0;
            r_ready_en    <= 1'b0;
            r_full        <= 1'b0;
            r_cut_through <= 1'b0;
        end else begin
            r_ready_en  <= 1'b1;
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_full      <= (w_fill_next == PW'(DEPTH));
            r_pkt_store <= r_pkt_store + PW'(w_push && i_axis_in_tlast) - PW'(w_pop && w_head_tlast);
            r_pkt_count <= r_pkt_count + PW'(w_push && i_axis_in_tlast) - PW'(w_out_fire && o_axis_out_tlast);
            if (w_pop && w_head_tlast) begin
                r_cut_through <= 1'b0;
            end else if ((PACKET_MODE != 0) && w_pop && r_full && (r_pkt_store == '0)) begin
                r_cut_through <= 1'b1;
            end
        end
    end

    generate
        if (REGISTER_OUTPUT != 0) begin : g_reg_out
            logic          r_out_valid;
            logic [EW-1:0] r_out_payload;

            assign w_pop       = w_eligible && (!r_out_valid || i_axis_out_ready);
            assign w_out_valid = r_out_valid;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_out_valid   <= 1'b0;
                    r_out_payload <= '0;
                end else if (w_pop) begin
                    r_out_valid   <= 1'b1;
                    r_out_payload <= w_head;
                end else if (i_axis_out_ready) begin
                    r_out_valid   <= 1'b0;
                end
            end

            assign {o_axis_out_data, o_axis_out_dest, o_axis_out_user, o_axis_out_tlast} = r_out_payload;
        end else begin : g_comb_out
            assign w_pop       = w_eligible && i_axis_out_ready;
            assign w_out_valid = w_eligible;
            assign {o_axis_out_data, o_axis_out_dest, o_axis_out_user, o_axis_out_tlast} =
                w_empty ? '0 : w_head;
        end
    endgenerate

    assign o_axis_out_valid = w_out_valid;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Scoreboard bench for axis_elastic_buffer across four parameter sets: streaming/back-pressure,
// packet mode (two depths) and a combinational-output variant.
module tb_axis_elastic_buffer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    // index 0: D4 reg-out cut-through, 1: D8 packet, 2: D4 packet, 3: D4 comb-out
    logic        in_valid [4];
    logic        in_tlast [4];
    logic        in_ready [4];
    logic [31:0] in_data  [4];
    logic [31:0] in_dest  [4];
    logic [31:0] in_user  [4];
    logic        out_ready[4];
    logic        out_valid[4];
    logic        out_tlast[4];
    logic [31:0] out_data [4];
    logic [31:0] out_dest [4];
    logic [31:0] out_user [4];
    logic        full     [4];
    logic [2:0]  fill_a, pkt_a, fill_c, pkt_c, fill_d, pkt_d;
    logic [3:0]  fill_b, pkt_b;

    logic [98:0] exp_q[$];
    int          first_valid[4] = '{-1, -1, -1, -1};
    int          first_fire [4] = '{0, 0, 0, 0};
    int          last_fire  [4] = '{0, 0, 0, 0};
    int          fire_cnt   [4] = '{0, 0, 0, 0};
    logic        prev_hold  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [96:0] prev_pay   [4];
    int          last_acc = 0;

    axis_elastic_buffer #(.DEPTH(4), .REGISTER_OUTPUT(1), .PACKET_MODE(0)) u_a (
        .clock(clock), .reset(reset),
        .i_axis_in_data(in_data[0]), .i_axis_in_dest(in_dest[0]), .i_axis_in_user(in_user[0]),
        .i_axis_in_tlast(in_tlast[0]), .i_axis_in_valid(in_valid[0]), .o_axis_in_ready(in_ready[0]),
        .o_axis_out_data(out_data[0]), .o_axis_out_dest(out_dest[0]), .o_axis_out_user(out_user[0]),
        .o_axis_out_tlast(out_tlast[0]), .o_axis_out_valid(out_valid[0]), .i_axis_out_ready(out_ready[0]),
        .o_fill_level(fill_a), .o_packet_count(pkt_a), .o_full(full[0]));

    axis_elastic_buffer #(.DEPTH(8), .REGISTER_OUTPUT(1), .PACKET_MODE(1)) u_b (
        .clock(clock), .reset(reset),
        .i_axis_in_data(in_data[1]), .i_axis_in_dest(in_dest[1]), .i_axis_in_user(in_user[1]),
        .i_axis_in_tlast(in_tlast[1]), .i_axis_in_valid(in_valid[1]), .o_axis_in_ready(in_ready[1]),
        .o_axis_out_data(out_data[1]), .o_axis_out_dest(out_dest[1]), .o_axis_out_user(out_user[1]),
        .o_axis_out_tlast(out_tlast[1]), .o_axis_out_valid(out_valid[1]), .i_axis_out_ready(out_ready[1]),
        .o_fill_level(fill_b), .o_packet_count(pkt_b), .o_full(full[1]));

    axis_elastic_buffer #(.DEPTH(4), .REGISTER_OUTPUT(1), .PACKET_MODE(1)) u_c (
        .clock(clock), .reset(reset),
        .i_axis_in_data(in_data[2]), .i_axis_in_dest(in_dest[2]), .i_axis_in_user(in_user[2]),
        .i_axis_in_tlast(in_tlast[2]), .i_axis_in_valid(in_valid[2]), .o_axis_in_ready(in_ready[2]),
        .o_axis_out_data(out_data[2]), .o_axis_out_dest(out_dest[2]), .o_axis_out_user(out_user[2]),
        .o_axis_out_tlast(out_tlast[2]), .o_axis_out_valid(out_valid[2]), .i_axis_out_ready(out_ready[2]),
        .o_fill_level(fill_c), .o_packet_count(pkt_c), .o_full(full[2]));

    axis_elastic_buffer #(.DEPTH(4), .REGISTER_OUTPUT(0), .PACKET_MODE(0)) u_d (
        .clock(clock), .reset(reset),
        .i_axis_in_data(in_data[3]), .i_axis_in_dest(in_dest[3]), .i_axis_in_user(in_user[3]),
        .i_axis_in_tlast(in_tlast[3]), .i_axis_in_valid(in_valid[3]), .o_axis_in_ready(in_ready[3]),
        .o_axis_out_data(out_data[3]), .o_axis_out_dest(out_dest[3]), .o_axis_out_user(out_user[3]),
        .o_axis_out_tlast(out_tlast[3]), .o_axis_out_valid(out_valid[3]), .i_axis_out_ready(out_ready[3]),
        .o_fill_level(fill_d), .o_packet_count(pkt_d), .o_full(full[3]));

    function automatic logic [96:0] beat(input logic [31:0] d, input logic last);
        return {d, d ^ 32'hA5A5_0000, ~d, last};
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send(input int k, input logic [31:0] d, input logic last);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_dest[k]  = d ^ 32'hA5A5_0000;
        in_user[k]  = ~d;
        in_tlast[k] = last;
        @(negedge clock);
        while (!in_ready[k] && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready[k]) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout dut%0d data %h: ready 0, required 1", k, d);
        end else begin
            exp_q.push_back({2'(k), beat(d, last)});
            last_acc = cyc;
        end
        @(posedge clock);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and enforces payload hold under stall.
    always @(negedge clock) begin : monitor
        logic [98:0] e;
        logic [96:0] got;
        for (int k = 0; k < 4; k++) begin
            got = {out_data[k], out_dest[k], out_user[k], out_tlast[k]};
            if (reset && prev_hold[k]) begin
                checks++;
                if (!out_valid[k] || got != prev_pay[k]) begin
                    fails++;
                    $display("FAIL axi_hold dut%0d: valid %0b payload %h, required valid 1 payload %h",
                             k, out_valid[k], got, prev_pay[k]);
                end
            end
            if (reset && out_valid[k] && first_valid[k] < 0) first_valid[k] = cyc;
            if (reset && out_valid[k] && out_ready[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat dut%0d: got %h, required no beat", k, got);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {2'(k), got}) begin
                        fails++;
                        $display("FAIL scoreboard dut%0d: got %h, required %h", k, {2'(k), got}, e);
                    end
                end
                if (fire_cnt[k] == 0) first_fire[k] = cyc;
                last_fire[k] = cyc;
                fire_cnt[k]++;
            end
            prev_hold[k] = reset && out_valid[k] && !out_ready[k];
            prev_pay[k]  = got;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int acc;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0; in_tlast[k] = 1'b0; in_data[k] = '0;
            in_dest[k] = '0; in_user[k] = '0; out_ready[k] = 1'b1;
        end

        // Reset release with a beat already offered on A
        in_valid[0] = 1'b1; in_data[0] = 32'h55; in_dest[0] = 32'h55 ^ 32'hA5A5_0000; in_user[0] = ~32'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("rst_ready_a", in_ready[0], 0);
            chk("rst_valid_a", out_valid[0], 0);
            chk("rst_data_a", out_data[0], 0);
            chk("rst_fill_a", fill_a, 0);
            chk("rst_pkt_a", pkt_a, 0);
            chk("rst_full_a", full[0], 0);
            chk("rst_valid_d", out_valid[3], 0);
            chk("rst_data_d", out_data[3], 0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("ready_first_cycle_a", in_ready[0], 0);
        chk("ready_first_cycle_b", in_ready[1], 0);
        chk("ready_first_cycle_d", in_ready[3], 0);
        @(negedge clock);
        chk("ready_after_release", in_ready[0], 1);
        exp_q.push_back({2'd0, beat(32'h55, 1'b0)});
        @(posedge clock);
        #1 in_valid[0] = 1'b0;
        drain();

        // Streaming on A
        first_valid[0] = -1; fire_cnt[0] = 0; acc = 0;
        for (int i = 1; i <= 16; i++) begin
            send(0, 32'(i), 1'b0);
            if (i == 1) acc = last_acc;
        end
        drain();
        chk("stream_latency", first_valid[0] - acc, 2);
        chk("stream_count", fire_cnt[0], 16);
        chk("stream_span", last_fire[0] - first_fire[0], 15);

        // Back-pressure on A
        out_ready[0] = 1'b0;
        idx = 1;
        for (int c = 0; c < 12; c++) begin
            in_valid[0] = 1'b1; in_tlast[0] = 1'b0; in_data[0] = 32'(idx);
            in_dest[0] = 32'(idx) ^ 32'hA5A5_0000; in_user[0] = ~32'(idx);
            @(negedge clock);
            if (in_ready[0]) begin
                exp_q.push_back({2'd0, beat(32'(idx), 1'b0)});
                idx++;
            end
            @(posedge clock);
            #1;
        end
        in_valid[0] = 1'b0;
        @(negedge clock);
        chk("bp_accepted", idx - 1, 5);
        chk("bp_full", full[0], 1);
        chk("bp_fill", fill_a, 4);
        chk("bp_ready", in_ready[0], 0);
        @(posedge clock);
        #1 out_ready[0] = 1'b1;
        for (int i = idx; i <= 10; i++) send(0, 32'(i), 1'b0);
        drain();
        chk("bp_full_after", full[0], 0);

        // Combinational output variant: latency 1, single-entry push/pop keeps fill at 1
        first_valid[3] = -1; fire_cnt[3] = 0;
        for (int i = 1; i <= 8; i++) begin
            send(3, 32'h300 + 32'(i), 1'b0);
            if (i == 1) acc = last_acc;
            chk("d_fill_one", fill_d, 1);
            chk("d_valid_cont", out_valid[3], 1);
        end
        drain();
        chk("d_latency", first_valid[3] - acc, 1);
        chk("d_span", last_fire[3] - first_fire[3], 7);
        chk("d_fill_empty", fill_d, 0);
        chk("d_pkt", pkt_d, 0);

        // Packet mode, DEPTH 8
        first_valid[1] = -1; fire_cnt[1] = 0;
        send(1, 32'hB1, 1'b0);
        send(1, 32'hB2, 1'b0);
        repeat (3) begin
            @(negedge clock);
            chk("pkt_hold_valid", out_valid[1], 0);
            chk("pkt_hold_count", pkt_b, 0);
        end
        chk("pkt_fill_two", fill_b, 2);
        @(posedge clock);
        #1;
        send(1, 32'hB3, 1'b1);
        acc = last_acc;
        @(negedge clock);
        chk("pkt_count_one", pkt_b, 1);
        drain();
        chk("pkt_latency", first_valid[1] - acc, 2);
        chk("pkt_count_zero", pkt_b, 0);
        chk("pkt_beats", fire_cnt[1], 3);

        // Oversize packet, DEPTH 4
        fire_cnt[2] = 0;
        for (int i = 1; i <= 4; i++) send(2, 32'hC00 + 32'(i), 1'b0);
        chk("over_full", full[2], 1);
        chk("over_ready", in_ready[2], 0);
        for (int i = 5; i <= 10; i++) send(2, 32'hC00 + 32'(i), (i == 10));
        drain();
        chk("over_beats", fire_cnt[2], 10);
        chk("over_pkt", pkt_c, 0);
        chk("over_fill", fill_c, 0);
        send(2, 32'hCA, 1'b0);
        repeat (3) begin
            @(negedge clock);
            chk("ct_cleared", out_valid[2], 0);
        end
        @(posedge clock);
        #1;
        send(2, 32'hCB, 1'b1);
        drain();

        // Reset mid-stream on A
        out_ready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) send(0, 32'hE0 + 32'(i), 1'b0);
        chk("mid_fill_pre", fill_a, 3);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        chk("mid_fill", fill_a, 0);
        chk("mid_valid", out_valid[0], 0);
        chk("mid_full", full[0], 0);
        out_ready[0] = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        for (int i = 1; i <= 3; i++) send(0, 32'hF0 + 32'(i), 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
